pe_dispatch: RTL and testbench

Instruction issue stage directly upstream of `pe_core_v3`. It buffers instruction words from the sequencer and reads source operands from a local 8×32 register file. It issues one `opcode`/`op1`/`op2`/`op3`/`valid_in` bundle at a time, using a scoreboard for RAW/WAW hazards. PE results (`result_out`/`result_valid`) are written back to the destination register in issue order.

---
 rtl/pe_dispatch.sv | 176 +++++++++++++++++
 tb/tb_pe_dispatch.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_dispatch.sv
// Issue stage for pe_core_v3: queues sequencer words, reads operands from an 8x32 register file, issues in order, writes results back.
// Latency: a word accepted on edge E issues on E+1 at the earliest; a dependent issues on the edge after its producer's writeback.
// Backpressure: in_ready drops while the instruction FIFO is full; issue stalls on scoreboard hazards or MAX_INFLIGHT outstanding.
module pe_dispatch #(
    parameter int DEPTH        = 4,  // power of two, >= 2
    parameter int MAX_INFLIGHT = 4   // power of two, >= 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] in_instr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        rf_wr_en,
    input  logic [2:0]  rf_wr_addr,
    input  logic [31:0] rf_wr_data,
    input  logic [2:0]  rf_rd_addr,
    output logic [31:0] rf_rd_data,
    output logic [31:0] pe_opcode,
    output logic [31:0] pe_op1,
    output logic [31:0] pe_op2,
    output logic [31:0] pe_op3,
    output logic        pe_valid,
    input  logic [31:0] pe_result,
    input  logic        pe_result_valid,
    output logic        busy,
    output logic        err_unexpected
);
    localparam int PW = $clog2(DEPTH);
    localparam int TW = $clog2(MAX_INFLIGHT);
    localparam logic [PW:0] IPTR_ONE = 1;
    localparam logic [TW:0] TPTR_ONE = 1;

    // Instruction FIFO: only bits [31:8] carry information, so the low byte is not stored.
    logic [23:0] ififo_mem [DEPTH];
    logic [PW:0] ififo_wr_ptr;
    logic [PW:0] ififo_rd_ptr;
    logic        ififo_full;
    logic        ififo_empty;
    logic        push_vld;
    logic        issue_vld;
    logic [23:0] head_dat;
    logic [6:0]  head_class;
    logic [4:0]  head_func;
    logic [2:0]  head_rd;
    logic [2:0]  head_rs1;
    logic [2:0]  head_rs2;
    logic [2:0]  head_rs3;
    logic        unused_instr_bits;

    // Destination tag FIFO: its occupancy is the inflight count.
    logic [2:0]  tag_mem [MAX_INFLIGHT];
    logic [TW:0] tag_wr_ptr;
    logic [TW:0] tag_rd_ptr;
    logic        tag_full;
    logic        tag_empty;
    logic [2:0]  wb_tag;
    logic        wb_vld;

    logic [7:0]  pending;
    logic [7:0]  pending_nxt;
    logic [31:0] rf [8];

    assign unused_instr_bits = ^in_instr[7:0];

    assign ififo_empty = (ififo_wr_ptr == ififo_rd_ptr);
    assign ififo_full  = (ififo_wr_ptr[PW-1:0] == ififo_rd_ptr[PW-1:0]) &&
                         (ififo_wr_ptr[PW] != ififo_rd_ptr[PW]);
    assign in_ready    = !ififo_full;
    assign push_vld    = in_valid && !ififo_full;

    assign head_dat    = ififo_mem[ififo_rd_ptr[PW-1:0]];
    assign head_class  = head_dat[23:17];
    assign head_func   = head_dat[16:12];
    assign head_rd     = head_dat[11:9];
    assign head_rs1    = head_dat[8:6];
    assign head_rs2    = head_dat[5:3];
    assign head_rs3    = head_dat[2:0];

    assign tag_empty   = (tag_wr_ptr == tag_rd_ptr);
    assign tag_full    = (tag_wr_ptr[TW-1:0] == tag_rd_ptr[TW-1:0]) &&
                         (tag_wr_ptr[TW] != tag_rd_ptr[TW]);
    assign wb_tag      = tag_mem[tag_rd_ptr[TW-1:0]];

    // Every field is checked regardless of opcode; the scoreboard is the pre-edge one, no bypass.
    assign issue_vld   = !ififo_empty && !tag_full &&
                         !pending[head_rs1] && !pending[head_rs2] &&
                         !pending[head_rs3] && !pending[head_rd];
    assign wb_vld      = pe_result_valid && !tag_empty;

    assign busy        = !ififo_empty || !tag_empty;
    assign rf_rd_data  = rf[rf_rd_addr];

    // Instruction FIFO storage (contents need no reset; pointers qualify them).
    always_ff @(posedge clk) begin
        if (push_vld) begin
            ififo_mem[ififo_wr_ptr[PW-1:0]] <= in_instr[31:8];
        end
    end

    // Instruction FIFO pointers: push on accept, pop on issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ififo_wr_ptr <= '0;
            ififo_rd_ptr <= '0;
        end else begin
            if (push_vld) ififo_wr_ptr <= ififo_wr_ptr + IPTR_ONE;
            if (issue_vld) ififo_rd_ptr <= ififo_rd_ptr + IPTR_ONE;
        end
    end

    // Tag FIFO storage: destination of each issued instruction, in issue order.
    always_ff @(posedge clk) begin
        if (issue_vld) begin
            tag_mem[tag_wr_ptr[TW-1:0]] <= head_rd;
        end
    end

    // Tag FIFO pointers: push on issue, pop on writeback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_wr_ptr <= '0;
            tag_rd_ptr <= '0;
        end else begin
            if (issue_vld) tag_wr_ptr <= tag_wr_ptr + TPTR_ONE;
            if (wb_vld)    tag_rd_ptr <= tag_rd_ptr + TPTR_ONE;
        end
    end

    // Scoreboard update: writeback clears its tag, issue marks the new destination.
    always_comb begin
        pending_nxt = pending;
        if (wb_vld)    pending_nxt[wb_tag]  = 1'b0;
        if (issue_vld) pending_nxt[head_rd] = 1'b1;
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending <= '0;
        else        pending <= pending_nxt;
    end

    // Register file: the writeback is applied after the host write so it wins a same-register collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) rf[i] <= '0;
        end else begin
            if (rf_wr_en) rf[rf_wr_addr] <= rf_wr_data;
            if (wb_vld)   rf[wb_tag]     <= pe_result;
        end
    end

    // Issue bundle: operands sampled from the pre-edge register file; held while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pe_valid  <= 1'b0;
            pe_opcode <= '0;
            pe_op1    <= '0;
            pe_op2    <= '0;
            pe_op3    <= '0;
        end else begin
            pe_valid <= issue_vld;
            if (issue_vld) begin
                pe_opcode <= {head_class, head_func, 20'd0};
                pe_op1    <= rf[head_rs1];
                pe_op2    <= rf[head_rs2];
                pe_op3    <= rf[head_rs3];
            end
        end
    end

    // Sticky flag for a result that arrives with nothing outstanding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_unexpected <= 1'b0;
        else if (pe_result_valid && tag_empty) err_unexpected <= 1'b1;
    end
endmodule

// File: tb/tb_pe_dispatch.sv
// Directed bench for pe_dispatch with a small in-order PE model driven from the clock task.
// Inputs change and outputs are sampled 1 ns after the rising edge.
// Expected values are hand-computed constants per scenario.
module tb_pe_dispatch;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in_instr;
    logic        in_valid;
    logic        in_ready;
    logic        rf_wr_en;
    logic [2:0]  rf_wr_addr;
    logic [31:0] rf_wr_data;
    logic [2:0]  rf_rd_addr;
    logic [31:0] rf_rd_data;
    logic [31:0] pe_opcode;
    logic [31:0] pe_op1;
    logic [31:0] pe_op2;
    logic [31:0] pe_op3;
    logic        pe_valid;
    logic [31:0] pe_result;
    logic        pe_result_valid;
    logic        busy;
    logic        err_unexpected;

    always #5 clk = ~clk;

    pe_dispatch #(.DEPTH(4), .MAX_INFLIGHT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_instr(in_instr), .in_valid(in_valid), .in_ready(in_ready),
        .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
        .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
        .pe_opcode(pe_opcode), .pe_op1(pe_op1), .pe_op2(pe_op2), .pe_op3(pe_op3),
        .pe_valid(pe_valid), .pe_result(pe_result), .pe_result_valid(pe_result_valid),
        .busy(busy), .err_unexpected(err_unexpected)
    );

    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          n_issued = 0;
    int          n_wb = 0;
    int          rel_cnt = 0;
    int          last_push_cyc = 0;
    bit          pe_auto = 1'b1;
    logic [31:0] res_q [$];
    int          issue_cyc [64];
    logic [31:0] issue_opc [64];
    logic [31:0] issue_op1 [64];
    logic [31:0] issue_op2 [64];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pe_model(input logic [4:0] func, input logic [31:0] a, input logic [31:0] b);
        if (func == 5'd2) return a - b;
        return a + b;
    endfunction

    function automatic logic [31:0] enc(input logic [4:0] func, input logic [2:0] rd,
                                        input logic [2:0] rs1, input logic [2:0] rs2, input logic [2:0] rs3);
        return {7'd1, func, rd, rs1, rs2, rs3, 8'd0};
    endfunction

    // One clock: log issues, then return PE results in order (immediately in auto mode, or rel_cnt of them).
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        pe_result_valid = 1'b0;
        if (pe_valid) begin
            if (n_issued < 64) begin
                issue_cyc[n_issued] = cyc;
                issue_opc[n_issued] = pe_opcode;
                issue_op1[n_issued] = pe_op1;
                issue_op2[n_issued] = pe_op2;
            end
            n_issued++;
            res_q.push_back(pe_model(pe_opcode[24:20], pe_op1, pe_op2));
        end
        if ((pe_auto || rel_cnt > 0) && res_q.size() != 0) begin
            pe_result       = res_q.pop_front();
            pe_result_valid = 1'b1;
            n_wb++;
            if (rel_cnt > 0) rel_cnt--;
        end
    endtask

    task automatic push(input logic [31:0] instr);
        int w = 0;
        while (!in_ready && w < 50) begin
            tick();
            w++;
        end
        chk("push_ready", in_ready, 1);
        in_instr = instr;
        in_valid = 1'b1;
        tick();
        last_push_cyc = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
        rf_wr_en   = 1'b1;
        rf_wr_addr = a;
        rf_wr_data = d;
        tick();
        rf_wr_en   = 1'b0;
    endtask

    task automatic chk_reg(input string tag, input logic [2:0] a, input logic [31:0] exp);
        rf_rd_addr = a;
        #1;
        chk(tag, rf_rd_data, exp);
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && (busy || res_q.size() != 0); k++) tick();
        chk("drain_idle", busy, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          b;
        int          wb0;
        logic [31:0] bp [9];
        logic [31:0] exp_rf [8];

        rst_n           = 1'b0;
        in_instr        = '0;
        in_valid        = 1'b0;
        rf_wr_en        = 1'b0;
        rf_wr_addr      = '0;
        rf_wr_data      = '0;
        rf_rd_addr      = '0;
        pe_result       = '0;
        pe_result_valid = 1'b0;
        repeat (2) tick();

        // Reset state
        chk("rst_in_ready", in_ready, 1);
        chk("rst_pe_valid", pe_valid, 0);
        chk("rst_opcode", pe_opcode, 0);
        chk("rst_op1", pe_op1, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_unexpected, 0);
        chk_reg("rst_r3", 3'd3, 0);
        rst_n = 1'b1;
        tick();

        // Basic ADD r3 = r1 + r2
        wr_reg(3'd1, 32'd10);
        wr_reg(3'd2, 32'd20);
        b = n_issued;
        push(enc(5'd1, 3'd3, 3'd1, 3'd2, 3'd0));
        drain();
        chk("add_cnt", n_issued - b, 1);
        chk("add_latency", issue_cyc[b] - last_push_cyc, 1);
        chk("add_opcode", issue_opc[b], 32'h0210_0000);
        chk("add_op1", issue_op1[b], 32'd10);
        chk("add_op2", issue_op2[b], 32'd20);
        chk_reg("add_r3", 3'd3, 32'd30);

        // RAW: ADD r3 = r1 + r2, then SUB r4 = r3 - r1
        wr_reg(3'd3, 32'd0);
        b = n_issued;
        push(enc(5'd1, 3'd3, 3'd1, 3'd2, 3'd0));
        push(enc(5'd2, 3'd4, 3'd3, 3'd1, 3'd0));
        drain();
        chk("raw_cnt", n_issued - b, 2);
        chk("raw_gap", issue_cyc[b+1] - issue_cyc[b], 2);
        chk("raw_sub_opcode", issue_opc[b+1], 32'h0220_0000);
        chk("raw_sub_op1", issue_op1[b+1], 32'd30);
        chk_reg("raw_r4", 3'd4, 32'd20);

        // Backpressure: PE silent, 9 independent instructions
        for (int i = 0; i < 9; i++) begin
            bp[i] = enc(5'd1, 3'(4 + (i % 4)), 3'(i % 4), (i < 4) ? 3'd1 : ((i < 8) ? 3'd2 : 3'd3), 3'd0);
        end
        pe_auto = 1'b0;
        b   = n_issued;
        wb0 = n_wb;
        for (int i = 0; i < 8; i++) push(bp[i]);
        chk("bp_full_ready", in_ready, 0);
        repeat (3) tick();
        chk("bp_issued", n_issued - b, 4);
        chk("bp_still_full", in_ready, 0);
        chk("bp_busy", busy, 1);
        chk("bp_back2back", issue_cyc[b+3] - issue_cyc[b], 3);
        rel_cnt = 4;
        push(bp[8]);
        chk("bp_resumed", (n_issued - b) > 4, 1);
        pe_auto = 1'b1;
        rel_cnt = 0;
        drain();
        chk("bp_issued_all", n_issued - b, 9);
        chk("bp_wb_all", n_wb - wb0, 9);
        chk_reg("bp_r4", 3'd4, 32'd30);
        chk_reg("bp_r5", 3'd5, 32'd30);
        chk_reg("bp_r6", 3'd6, 32'd40);
        chk_reg("bp_r7", 3'd7, 32'd50);

        // Throughput: three independent instructions issue on consecutive cycles
        b = n_issued;
        push(enc(5'd1, 3'd4, 3'd1, 3'd2, 3'd0));
        push(enc(5'd1, 3'd5, 3'd1, 3'd1, 3'd0));
        push(enc(5'd1, 3'd6, 3'd2, 3'd2, 3'd0));
        drain();
        chk("tp_gap1", issue_cyc[b+1] - issue_cyc[b], 1);
        chk("tp_gap2", issue_cyc[b+2] - issue_cyc[b+1], 1);
        chk_reg("tp_r5", 3'd5, 32'd20);

        // Unsolicited result while idle
        exp_rf = '{32'd0, 32'd10, 32'd20, 32'd30, 32'd30, 32'd20, 32'd40, 32'd50};
        chk("uns_err_before", err_unexpected, 0);
        pe_result       = 32'h0000_DEAD;
        pe_result_valid = 1'b1;
        tick();
        chk("uns_err", err_unexpected, 1);
        for (int r = 1; r < 8; r++) chk_reg("uns_reg", 3'(r), exp_rf[r]);

        // Host write and writeback to r5 on the same edge
        pe_auto = 1'b0;
        wr_reg(3'd6, 32'd99);
        b = n_issued;
        push(enc(5'd1, 3'd5, 3'd6, 3'd0, 3'd0));
        for (int k = 0; k < 20 && n_issued == b; k++) tick();
        chk("col_issued", n_issued - b, 1);
        chk("col_q", res_q.size(), 1);
        if (res_q.size() != 0) pe_result = res_q.pop_front();
        pe_result_valid = 1'b1;
        rf_wr_en   = 1'b1;
        rf_wr_addr = 3'd5;
        rf_wr_data = 32'd7;
        tick();
        rf_wr_en = 1'b0;
        chk("col_busy", busy, 0);
        chk_reg("col_r5", 3'd5, 32'd99);
        chk("col_err_sticky", err_unexpected, 1);

        // Reset with 2 in flight and 2 queued
        b = n_issued;
        push(enc(5'd1, 3'd1, 3'd0, 3'd0, 3'd0));
        push(enc(5'd1, 3'd2, 3'd0, 3'd0, 3'd0));
        push(enc(5'd1, 3'd1, 3'd0, 3'd0, 3'd0));
        push(enc(5'd1, 3'd3, 3'd0, 3'd0, 3'd0));
        chk("mid_inflight", n_issued - b, 2);
        chk("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_pe_valid", pe_valid, 0);
        chk("mid_rst_opcode", pe_opcode, 0);
        chk("mid_rst_op1", pe_op1, 0);
        chk("mid_rst_op2", pe_op2, 0);
        chk("mid_rst_op3", pe_op3, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_err", err_unexpected, 0);
        res_q.delete();
        tick();
        for (int r = 1; r < 8; r++) chk_reg("mid_rst_reg", 3'(r), 0);
        rst_n = 1'b1;
        b = n_issued;
        repeat (5) tick();
        chk("mid_no_issue", n_issued - b, 0);
        chk("mid_busy_after", busy, 0);
        pe_result       = 32'd5;
        pe_result_valid = 1'b1;
        tick();
        chk("mid_late_err", err_unexpected, 1);
        chk_reg("mid_late_r1", 3'd1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
